// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: runs LOAD/UP/DOWN/WAIT commands against an external up/down counter.
// Optional CNT_SEQ_OVF_STOP_EN ends a RUN early on the first sampled cnt_ovf.
module counter_cmd_sequencer #(
  parameter int bits = 8
) (
  input  logic            c,
  input  logic            clr,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [bits-1:0] cmd_arg,
  output logic            cnt_en,
  output logic            cnt_dir,
  output logic            cnt_ld,
  output logic [bits-1:0] cnt_in,
  input  logic            cnt_ovf,
  output logic            busy,
  output logic            done,
  output logic            ovf_seen
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [bits-1:0] step_q, step_d, cnt_in_q, cnt_in_d;
  logic cnt_en_q, cnt_en_d, cnt_dir_q, cnt_dir_d, cnt_ld_q, cnt_ld_d;
  logic busy_q, busy_d, done_q, done_d, ovf_seen_q, ovf_seen_d;
  logic last;
  assign cmd_ready = state_q == IDLE && !clr;
`ifdef CNT_SEQ_OVF_STOP_EN
  assign last = step_q == bits'(1) || (state_q == RUN && cnt_ovf);
`else
  assign last = step_q == bits'(1);
`endif
  // Outputs are registered, so each branch computes the values for the state being entered.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_en_d   = 1'b0;
    cnt_ld_d   = 1'b0;
    cnt_dir_d  = cnt_dir_q;
    cnt_in_d   = cnt_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_seen_d = ovf_seen_q | (cnt_ovf & busy_q);
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        ovf_seen_d = 1'b0;
        busy_d     = 1'b1;
        if (cmd_op == 2'b00) begin
          state_d  = LOAD;
          cnt_ld_d = 1'b1;
          cnt_in_d = cmd_arg;
        end else begin
          cnt_dir_d = cmd_op == 2'b11 ? cnt_dir_q : cmd_op[1];
          step_d    = cmd_arg;
          if (cmd_arg == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = cmd_op == 2'b11 ? WAIT : RUN;
            cnt_en_d = cmd_op != 2'b11;
          end
        end
      end
      LOAD: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      RUN, WAIT: begin
        if (last) begin
          state_d = DONE;
          step_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          step_d   = step_q - bits'(1);
          cnt_en_d = state_q == RUN;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge c or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      step_q     <= '0;
      cnt_en_q   <= 1'b0;
      cnt_dir_q  <= 1'b0;
      cnt_ld_q   <= 1'b0;
      cnt_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_en_q   <= cnt_en_d;
      cnt_dir_q  <= cnt_dir_d;
      cnt_ld_q   <= cnt_ld_d;
      cnt_in_q   <= cnt_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_seen_q <= ovf_seen_d;
    end
  end
  assign cnt_en   = cnt_en_q;
  assign cnt_dir  = cnt_dir_q;
  assign cnt_ld   = cnt_ld_q;
  assign cnt_in   = cnt_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf_seen = ovf_seen_q;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: drives commands at a 3-bit sequencer wired to a modelled wrapping counter.
module tb_counter_cmd_sequencer;
  logic c = 1'b0, clr = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_arg = 3'd0, cnt_in, cnt_val;
  logic cnt_en, cnt_dir, cnt_ld, cnt_ovf, busy, done, ovf_seen;
  int tests = 0, failed = 0;
  bit last_dir = 1'b0;

  counter_cmd_sequencer #(.bits(3)) dut (
    .c(c), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_ld(cnt_ld), .cnt_in(cnt_in),
    .cnt_ovf(cnt_ovf), .busy(busy), .done(done), .ovf_seen(ovf_seen)
  );

  always #5 c = ~c;

  // Environment counter: wraps modulo 8 and flags the wrapping step.
  assign cnt_ovf = cnt_en && (cnt_dir ? cnt_val == 3'd0 : cnt_val == 3'd7);
  always @(posedge c or posedge clr)
    if (clr) cnt_val <= 3'd0;
    else if (cnt_ld) cnt_val <= cnt_in;
    else if (cnt_en) cnt_val <= cnt_dir ? cnt_val - 3'd1 : cnt_val + 3'd1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge c); #1;
  endtask

  task automatic run_cmd(input bit [1:0] op, input int arg, input bit keep = 0,
                         input bit [1:0] nop = 0, input int narg = 0);
    int start, exp_en, exp_lat, exp_fin, stop_at, lat, en, ld, dirbad, ldbad, busybad, readybad;
    bit wraps, exp_ovf, exp_dir;
    cmd_op = op; cmd_arg = 3'(arg); cmd_valid = 1'b1;
    for (int w = 0; w < 50 && !cmd_ready; w++) step();
    tests++;
    if (!cmd_ready) begin failed++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready); cmd_valid = 1'b0; return; end
    start   = int'(cnt_val);
    wraps   = (op == 2'd1 && start + arg > 7) || (op == 2'd2 && arg > start);
    stop_at = op == 2'd1 ? 8 - start : start + 1;
`ifdef CNT_SEQ_OVF_STOP_EN
    exp_en = (op == 2'd1 || op == 2'd2) ? (wraps ? stop_at : arg) : 0;
`else
    exp_en = (op == 2'd1 || op == 2'd2) ? arg : 0;
`endif
    exp_ovf = wraps;
    exp_lat = op == 2'd0 ? 2 : (op == 2'd3 ? arg : exp_en) + 1;
    exp_fin = op == 2'd0 ? arg : op == 2'd1 ? (start + exp_en) % 8 : op == 2'd2 ? (start - exp_en + 8) % 8 : start;
    if (op == 2'd1 || op == 2'd2) last_dir = op == 2'd2;
    exp_dir = last_dir;
    step();
    if (keep) begin cmd_op = nop; cmd_arg = 3'(narg); end else cmd_valid = 1'b0;
    en = 0; ld = 0; dirbad = 0; ldbad = 0; busybad = 0; readybad = 0;
    for (lat = 1; lat <= 40 && !done; lat++) begin
      if (cnt_en) begin en++; if (cnt_dir !== (op == 2'd2)) dirbad++; end
      if (cnt_ld) begin ld++; if (cnt_in !== 3'(arg)) ldbad++; end
      if (busy !== 1'b1) busybad++;
      if (cmd_ready !== 1'b0) readybad++;
      step();
    end
    tests++;
    if (!done) begin failed++; $display("FAIL done_missing: op=%0d arg=%0d no done within %0d cycles", op, arg, lat); return; end
    tests++; if (lat != exp_lat) begin failed++; $display("FAIL latency: op=%0d arg=%0d got %0d required %0d", op, arg, lat, exp_lat); end
    tests++; if (en != exp_en) begin failed++; $display("FAIL en_cycles: op=%0d arg=%0d start=%0d got %0d required %0d", op, arg, start, en, exp_en); end
    tests++; if (ld != (op == 2'd0 ? 1 : 0) || ldbad != 0) begin failed++; $display("FAIL ld_cycles: op=%0d got %0d (bad cnt_in %0d) required %0d", op, ld, ldbad, op == 2'd0); end
    tests++; if (dirbad + busybad + readybad != 0) begin failed++; $display("FAIL in_progress: dirbad=%0d busybad=%0d readybad=%0d required all 0", dirbad, busybad, readybad); end
    tests++; if ({busy, cmd_ready, cnt_en, cnt_ld} !== 4'b0000) begin failed++; $display("FAIL done_cycle: busy/ready/en/ld=%b required 0000", {busy, cmd_ready, cnt_en, cnt_ld}); end
    tests++; if (ovf_seen !== exp_ovf) begin failed++; $display("FAIL ovf_seen: op=%0d arg=%0d start=%0d got %b required %b", op, arg, start, ovf_seen, exp_ovf); end
    tests++; if (cnt_dir !== exp_dir) begin failed++; $display("FAIL dir_hold: got %b required %b", cnt_dir, exp_dir); end
    step();
    tests++; if ({done, cmd_ready} !== 2'b01) begin failed++; $display("FAIL after_done: done/ready=%b required 01", {done, cmd_ready}); end
    tests++; if (int'(cnt_val) != exp_fin) begin failed++; $display("FAIL counter_final: got %0d required %0d", cnt_val, exp_fin); end
    tests++; if (op == 2'd0 && cnt_in !== 3'(arg)) begin failed++; $display("FAIL cnt_in_hold: got %0d required %0d", cnt_in, arg); end
  endtask

  task automatic test_reset();
    clr = 1'b1; #3;
    tests++; if ({cnt_en, cnt_dir, cnt_ld, cnt_in, busy, done, ovf_seen, cmd_ready} !== 10'd0) begin failed++; $display("FAIL reset_outputs: got %b required 0", {cnt_en, cnt_dir, cnt_ld, cnt_in, busy, done, ovf_seen, cmd_ready}); end
    step(); step();
    clr = 1'b0; #1;
    tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    last_dir = 1'b0;
  endtask

  task automatic test_load();
    run_cmd(2'd0, 5);
    run_cmd(2'd0, 0);
  endtask

  task automatic test_up_down();
    run_cmd(2'd0, 0);
    run_cmd(2'd1, 6);
    run_cmd(2'd2, 0);
    run_cmd(2'd2, 3);
    run_cmd(2'd3, 4);
    run_cmd(2'd3, 0);
  endtask

  task automatic test_ovf();
    run_cmd(2'd0, 3);
    run_cmd(2'd1, 7);
    run_cmd(2'd0, 1);
    run_cmd(2'd2, 5);
  endtask

  task automatic test_clr_abort();
    int extra_done;
    run_cmd(2'd0, 2);
    cmd_op = 2'd1; cmd_arg = 3'd6; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    tests++; if ({busy, cnt_en} !== 2'b11) begin failed++; $display("FAIL abort_running: busy/en=%b required 11", {busy, cnt_en}); end
    #2 clr = 1'b1; #1;
    tests++; if ({cnt_en, cnt_dir, cnt_ld, cnt_in, busy, done, ovf_seen, cmd_ready} !== 10'd0) begin failed++; $display("FAIL abort_async: got %b required 0", {cnt_en, cnt_dir, cnt_ld, cnt_in, busy, done, ovf_seen, cmd_ready}); end
    #2 clr = 1'b0;
    last_dir = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin step(); if (done) extra_done++; end
    tests++; if (extra_done != 0 || cmd_ready !== 1'b1) begin failed++; $display("FAIL abort_no_done: done pulses=%0d ready=%b required 0 and 1", extra_done, cmd_ready); end
    run_cmd(2'd3, 2);
  endtask

  task automatic test_back_to_back();
    run_cmd(2'd1, 3, 1'b1, 2'd2, 2);
    tests++; if (cmd_valid !== 1'b1) begin failed++; $display("FAIL b2b_valid: got %b required 1", cmd_valid); end
    run_cmd(2'd2, 2, 1'b1, 2'd0, 6);
    run_cmd(2'd0, 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
  endtask

  initial begin
    test_reset();
    test_load();
    test_up_down();
    test_ovf();
    test_clr_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/counter_cmd_sequencer.md
COUNTER_CMD_SEQUENCER -- requirements
Module: counter_cmd_sequencer

Interface
REQ-001 Parameter: bits, default 8, width of cnt_in and cmd_arg.
REQ-002 Port: c  input  1  clock, all state on rising edge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_valid  input  1  command offered.
REQ-005 Port: cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 Port: cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 WAIT.
REQ-007 Port: cmd_arg  input  bits  preset value (LOAD) or cycle count (UP/DOWN/WAIT).
REQ-008 Port: cnt_en  output  1  counter enable.
REQ-009 Port: cnt_dir  output  1  counter direction, 0 up, 1 down.
REQ-010 Port: cnt_ld  output  1  counter preset load strobe.
REQ-011 Port: cnt_in  output  bits  counter preset value.
REQ-012 Port: cnt_ovf  input  1  counter overflow/wrap flag.
REQ-013 Port: busy  output  1  command in progress.
REQ-014 Port: done  output  1  one-cycle completion pulse.
REQ-015 Port: ovf_seen  output  1  sticky: cnt_ovf seen during current/last command.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, WAIT, DONE; all outputs registered except cmd_ready.
REQ-017 cmd_ready SHALL equal (state==IDLE) and not clr; accept = cmd_valid and cmd_ready at rising edge.
REQ-018 On accept: op/arg latched, ovf_seen cleared, busy=1 from next cycle; LOAD->LOAD, UP/DOWN->RUN, WAIT->WAIT.
REQ-019 LOAD: exactly one cycle cnt_ld=1, cnt_in=latched arg, cnt_en=0; then DONE.
REQ-020 RUN: cnt_en=1 for exactly arg cycles, cnt_dir=0 (UP) or 1 (DOWN), cnt_ld=0; then DONE.
REQ-021 WAIT: all cnt_* strobes 0 for exactly arg cycles; then DONE.
REQ-022 arg=0 for UP/DOWN/WAIT: zero active cycles, go directly to DONE on next cycle.
REQ-023 DONE: one cycle, done=1, busy=0, then IDLE; next command accepted no earlier than the cycle after done.
REQ-024 cnt_in SHALL hold last loaded value outside LOAD; cnt_dir holds last direction outside RUN.
REQ-025 ovf_seen SHALL set in any cycle cnt_ovf=1 while busy, and hold until next accept.
REQ-026 Step counter is bits wide, counts down from arg; max run length 2^bits-1 cycles.
REQ-027 cmd_op/cmd_arg changes while not accepting SHALL have no effect.

Reset
REQ-028 clr=1 SHALL immediately force state IDLE and cnt_en, cnt_dir, cnt_ld, busy, done, ovf_seen=0, cnt_in=0, step counter=0, independent of c.
REQ-029 clr mid-command SHALL abort it without a done pulse; first accept possible on first edge after clr deasserts.

Configuration
REQ-030 Macro CNT_SEQ_OVF_STOP_EN defined: RUN SHALL end early when cnt_ovf=1 is sampled; that cycle is the last cnt_en cycle, then DONE with ovf_seen=1.
REQ-031 Macro undefined: cnt_ovf only affects ovf_seen; RUN always lasts full arg cycles.

Verification
REQ-032 bits=3, LOAD arg=5 accepted at edge k -> cnt_ld=1, cnt_in=5 cycle k+1 only; done=1 cycle k+2; cmd_ready=1 cycle k+3.
REQ-033 UP arg=6 -> cnt_en=1, cnt_dir=0 exactly 6 cycles; done next cycle; cnt_ld=0 throughout.
REQ-034 DOWN arg=0 -> no cnt_en cycle; done one cycle after accept; cnt_dir=1.
REQ-035 Counter preset 3, UP arg=7, cnt_ovf at 7->0 wrap -> ovf_seen=1; macro defined: 5 enable cycles then done; undefined: 7 enable cycles.
REQ-036 clr pulsed during RUN cycle 3 of UP arg=6 -> all outputs 0 asynchronously, no done pulse, new WAIT arg=2 accepted after clr, 2 idle cycles then done.
REQ-037 cmd_valid held high with two queued commands -> cmd_ready low from accept through done; second command accepted in cycle after done.
